ifu_axi_fetch: RTL and testbench
================================

Name: ifu_axi_fetch

Overview:
- Instruction-fetch front end; sits between the PC unit and the decoder.
- Accepts a fetch PC over a valid/ready handshake and issues one single-beat AXI4 read on the core's master read channels.
- Captures the returned word and presents it to the decoder over a second valid/ready handshake.
- At most one fetch is outstanding at a time.

Parameters:
ADDR_W, 32, address and PC width
DATA_W, 32, AXI data width and instruction width
AXI_ID, 4'h0, ID driven on arid_o and expected on rid_i

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
pc_valid_i  input  1  fetch request valid
pc_ready_o  output  1  block can accept a PC
pc_i  input  ADDR_W  fetch address
inst_valid_o  output  1  fetched instruction valid
inst_ready_i  input  1  decoder accepts instruction
inst_o  output  DATA_W  fetched instruction
inst_pc_o  output  ADDR_W  PC of inst_o
fetch_err_o  output  1  fetch fault, qualified by inst_valid_o
arvalid_o  output  1  AXI AR valid
arready_i  input  1  AXI AR ready
araddr_o  output  ADDR_W  AXI AR address
arid_o  output  4  AXI AR id
arlen_o  output  8  AXI AR len
arsize_o  output  3  AXI AR size
arburst_o  output  2  AXI AR burst
rvalid_i  input  1  AXI R valid
rready_o  output  1  AXI R ready
rdata_i  input  DATA_W  AXI R data
rresp_i  input  2  AXI R response
rlast_i  input  1  AXI R last
rid_i  input  4  AXI R id

Behaviour:

Reset:
- rst_i low forces state IDLE immediately, independent of clk_i.
- Reset values: inst_o=0, inst_pc_o=0, fetch_err_o=0, araddr_o=0, arvalid_o=0, rready_o=0, inst_valid_o=0.
- A reset mid-transaction abandons the transfer. No response draining is required, because reset is system-wide.

Constant outputs:
- arid_o=AXI_ID, arlen_o=0, arsize_o=3'b010, arburst_o=2'b01 (INCR).

States:
- IDLE:
  - pc_ready_o=1; all other handshake outputs 0.
  - On pc_valid_i: latch pc_i into araddr_o and inst_pc_o.
  - If pc_i[1:0]==0, go to AR.
  - If misaligned: inst_o=0, fetch_err_o=1, go to OUT with no bus access.
- AR:
  - arvalid_o=1. araddr_o is held stable until arready_i.
  - On arready_i go to R.
  - rready_o stays 0 in this state.
- R:
  - rready_o=1.
  - On rvalid_i: inst_o<=rdata_i.
  - fetch_err_o<=(rresp_i!=0) | (rid_i!=AXI_ID) | !rlast_i.
  - Go to OUT.
- OUT:
  - inst_valid_o=1. inst_o, inst_pc_o and fetch_err_o are held stable until inst_ready_i.
  - On inst_ready_i go to IDLE.

Handshake rules:
- pc_ready_o is asserted only in IDLE. There is no request bypass or prefetch.
- arvalid_o never deasserts before arready_i.
- rready_o never asserts before the AR handshake completes.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

Latency:
- pc accepted at cycle 0.
- arvalid_o high at cycle 1.
- With arready_i=1 at cycle 1 and rvalid_i=1 at cycle 2, inst_valid_o rises at cycle 3.
- Each stall cycle on arready_i, rvalid_i or inst_ready_i adds one cycle.
- Throughput is at most one instruction per 4 cycles.

Boundary conditions:
- pc_valid_i asserted outside IDLE is ignored (not accepted).
- rvalid_i arriving while in AR is not consumed.
- rresp_i SLVERR/DECERR still delivers rdata_i, with fetch_err_o=1.
- PC 0xFFFF_FFFC is fetched normally; there is no wrap handling.

Test Plan:
- pc_i=0x8000_0000, arready_i=1 immediately, rvalid_i=1 next cycle with rdata_i=0x0000_0413, rresp_i=0, rid_i=0, rlast_i=1, inst_ready_i=1 -> araddr_o=0x8000_0000 at cycle 1; inst_valid_o at cycle 3 with inst_o=0x0000_0413, inst_pc_o=0x8000_0000, fetch_err_o=0; pc_ready_o high again at cycle 4.
- arready_i held low 5 cycles, then rvalid_i delayed 3 cycles, inst_ready_i delayed 2 cycles -> arvalid_o/araddr_o stable throughout the AR stall; rready_o=0 until the AR handshake; inst_o stable while inst_valid_o & !inst_ready_i; pc_ready_o=0 the whole time.
- rresp_i=2'b10 with rdata_i=0xDEAD_BEEF -> inst_o=0xDEAD_BEEF, fetch_err_o=1; next fetch with rresp_i=0 -> fetch_err_o=0.
- pc_i=0x8000_0002 -> no arvalid_o ever; inst_valid_o one cycle after accept with inst_o=0, fetch_err_o=1, inst_pc_o=0x8000_0002.
- rst_i pulled low asynchronously while in R -> arvalid_o, rready_o, inst_valid_o drop to 0 before the next clk_i edge; after release pc_ready_o=1 and a fresh fetch of 0x8000_0004 completes normally.

Source files
------------

// File: rtl/ifu_axi_fetch_if.sv
// Signal bundle between the fetch front end, the PC unit, the decoder and the AXI read channels.
// The master modport is the fetch unit's view; slave is the view of everything around it.
interface ifu_axi_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic [ADDR_W-1:0] pc_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              fetch_err_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [ADDR_W-1:0] araddr_o;
    logic [3:0]        arid_o;
    logic [7:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              rvalid_i;
    logic              rready_o;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;
    logic [3:0]        rid_i;

    modport master (
        input  pc_valid_i, pc_i, inst_ready_i, arready_i,
               rvalid_i, rdata_i, rresp_i, rlast_i, rid_i,
        output pc_ready_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o,
               arvalid_o, araddr_o, arid_o, arlen_o, arsize_o, arburst_o, rready_o
    );

    modport slave (
        output pc_valid_i, pc_i, inst_ready_i, arready_i,
               rvalid_i, rdata_i, rresp_i, rlast_i, rid_i,
        input  pc_ready_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o,
               arvalid_o, araddr_o, arid_o, arlen_o, arsize_o, arburst_o, rready_o
    );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch front end: takes one PC, issues a single-beat AXI4 read and hands
// the returned word to the decoder. Only one fetch is ever in flight.
module ifu_axi_fetch #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [3:0]  AXI_ID = 4'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ifu_axi_fetch_if.master     bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state;

    assign dbg_state_o   = state;
    assign bus.arid_o    = AXI_ID;
    assign bus.arlen_o   = 8'd0;
    assign bus.arsize_o  = 3'b010;
    assign bus.arburst_o = 2'b01;

    // Every channel transfers on a rising edge where valid and ready are both high;
    // a valid, once raised, holds itself and its payload until that edge.
    // All outputs are registers updated together with the state, so no input
    // ever reaches an output combinationally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= IDLE;
            bus.pc_ready_o   <= 1'b1;
            bus.arvalid_o    <= 1'b0;
            bus.rready_o     <= 1'b0;
            bus.inst_valid_o <= 1'b0;
            bus.araddr_o     <= {ADDR_W{1'b0}};
            bus.inst_pc_o    <= {ADDR_W{1'b0}};
            bus.inst_o       <= {DATA_W{1'b0}};
            bus.fetch_err_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pc_valid_i) begin
                        bus.araddr_o   <= bus.pc_i;
                        bus.inst_pc_o  <= bus.pc_i;
                        bus.pc_ready_o <= 1'b0;
                        if (bus.pc_i[1:0] == 2'b00) begin
                            bus.arvalid_o <= 1'b1;
                            state         <= AR;
                        end else begin
                            // Misaligned PC faults locally and never touches the bus.
                            bus.inst_o       <= {DATA_W{1'b0}};
                            bus.fetch_err_o  <= 1'b1;
                            bus.inst_valid_o <= 1'b1;
                            state            <= OUT;
                        end
                    end
                end
                AR: begin
                    if (bus.arready_i) begin
                        bus.arvalid_o <= 1'b0;
                        bus.rready_o  <= 1'b1;
                        state         <= R;
                    end
                end
                R: begin
                    if (bus.rvalid_i) begin
                        bus.inst_o       <= bus.rdata_i;
                        bus.fetch_err_o  <= (bus.rresp_i != 2'b00) | (bus.rid_i != AXI_ID) | !bus.rlast_i;
                        bus.rready_o     <= 1'b0;
                        bus.inst_valid_o <= 1'b1;
                        state            <= OUT;
                    end
                end
                OUT: begin
                    if (bus.inst_ready_i) begin
                        bus.inst_valid_o <= 1'b0;
                        bus.pc_ready_o   <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Bench for ifu_axi_fetch: a vector table of fetches with chosen stall patterns,
// random fetches, and hand-written sequences for the multi-cycle corner cases.
module tb_ifu_axi_fetch;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int EW     = DATA_W + ADDR_W + 1;

    typedef struct {
        logic [31:0] pc;
        int          ar_dly;
        int          r_dly;
        int          i_dly;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [3:0]  rid;
        logic        rlast;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          checks;
    int          failures;
    logic [EW-1:0] exp_q[$];

    ifu_axi_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    ifu_axi_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_ID(4'h0)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.pc_valid_i   = 1'b0;
        bus.pc_i         = '0;
        bus.inst_ready_i = 1'b0;
        bus.arready_i    = 1'b0;
        bus.rvalid_i     = 1'b0;
        bus.rdata_i      = '0;
        bus.rresp_i      = '0;
        bus.rlast_i      = 1'b0;
        bus.rid_i        = '0;
    endtask

    // Drives one complete fetch with fixed stall counts; all driving and sampling on negedge.
    task automatic run_fetch(input vec_t v);
        int            n;
        logic [EW-1:0] e;
        n = 0;
        while (bus.pc_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pc_ready_wait", 64'(n < 20), 1);
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = v.pc;
        @(negedge clk);
        exp_q.push_back({v.exp_inst, v.pc, v.exp_err});
        check("pc_ready_busy", bus.pc_ready_o, 0);
        // A competing request while busy must be ignored.
        bus.pc_i = ~v.pc;
        if (v.pc[1:0] == 2'b00) begin
            repeat (v.ar_dly) begin
                bus.rvalid_i = 1'b1;
                bus.rdata_i  = $urandom;
                check("ar_stall_arvalid", bus.arvalid_o, 1);
                check("ar_stall_araddr", bus.araddr_o, v.pc);
                check("ar_stall_rready", bus.rready_o, 0);
                @(negedge clk);
            end
            bus.rvalid_i = 1'b0;
            check("ar_arvalid", bus.arvalid_o, 1);
            check("ar_araddr", bus.araddr_o, v.pc);
            check("ar_rready", bus.rready_o, 0);
            bus.arready_i = 1'b1;
            @(negedge clk);
            bus.arready_i = 1'b0;
            check("r_arvalid", bus.arvalid_o, 0);
            repeat (v.r_dly) begin
                check("r_stall_rready", bus.rready_o, 1);
                check("r_stall_inst_valid", bus.inst_valid_o, 0);
                @(negedge clk);
            end
            check("r_rready", bus.rready_o, 1);
            bus.rvalid_i = 1'b1;
            bus.rdata_i  = v.rdata;
            bus.rresp_i  = v.rresp;
            bus.rid_i    = v.rid;
            bus.rlast_i  = v.rlast;
            @(negedge clk);
            bus.rvalid_i = 1'b0;
            bus.rdata_i  = $urandom;
            check("out_rready", bus.rready_o, 0);
        end else begin
            check("misalign_arvalid", bus.arvalid_o, 0);
        end
        e = exp_q[0];
        repeat (v.i_dly) begin
            check("out_stall_valid", bus.inst_valid_o, 1);
            check("out_stall_inst", bus.inst_o, e[EW-1 -: DATA_W]);
            check("out_stall_pc", bus.inst_pc_o, e[ADDR_W:1]);
            check("out_stall_err", bus.fetch_err_o, e[0]);
            @(negedge clk);
        end
        check("out_valid", bus.inst_valid_o, 1);
        check("out_arvalid", bus.arvalid_o, 0);
        bus.inst_ready_i = 1'b1;
        e = exp_q.pop_front();
        check("sb_inst", bus.inst_o, e[EW-1 -: DATA_W]);
        check("sb_pc", bus.inst_pc_o, e[ADDR_W:1]);
        check("sb_err", bus.fetch_err_o, e[0]);
        @(negedge clk);
        bus.inst_ready_i = 1'b0;
        bus.pc_valid_i   = 1'b0;
        check("idle_inst_valid", bus.inst_valid_o, 0);
        check("idle_pc_ready", bus.pc_ready_o, 1);
    endtask

    initial begin
        vec_t vecs[10];
        vec_t rv;
        checks   = 0;
        failures = 0;
        vecs[0] = '{32'h8000_0000, 0, 0, 0, 32'h0000_0413, 2'b00, 4'h0, 1'b1, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0010, 5, 3, 2, 32'h1234_5678, 2'b00, 4'h0, 1'b1, 32'h1234_5678, 1'b0};
        vecs[2] = '{32'h1000_0000, 0, 1, 0, 32'hDEAD_BEEF, 2'b10, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{32'h1000_0004, 0, 0, 1, 32'h00A0_0093, 2'b00, 4'h0, 1'b1, 32'h00A0_0093, 1'b0};
        vecs[4] = '{32'h8000_0002, 0, 0, 0, 32'h5555_5555, 2'b00, 4'h0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_FFFC, 1, 0, 0, 32'hCAFE_F00D, 2'b00, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{32'h2000_0000, 0, 0, 0, 32'h0000_0011, 2'b11, 4'h0, 1'b1, 32'h0000_0011, 1'b1};
        vecs[7] = '{32'h2000_0008, 0, 0, 0, 32'h0000_0022, 2'b00, 4'h5, 1'b1, 32'h0000_0022, 1'b1};
        vecs[8] = '{32'h2000_000C, 2, 0, 0, 32'h0000_0033, 2'b00, 4'h0, 1'b0, 32'h0000_0033, 1'b1};
        vecs[9] = '{32'h3000_0001, 0, 0, 3, 32'h7777_7777, 2'b00, 4'h0, 1'b1, 32'h0000_0000, 1'b1};

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pc_ready", bus.pc_ready_o, 1);
        check("rst_arvalid", bus.arvalid_o, 0);
        check("rst_rready", bus.rready_o, 0);
        check("rst_inst_valid", bus.inst_valid_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_inst_pc", bus.inst_pc_o, 0);
        check("rst_err", bus.fetch_err_o, 0);
        check("rst_araddr", bus.araddr_o, 0);
        check("rst_state", dbg_state, 0);
        check("const_ar", {bus.arid_o, bus.arlen_o, bus.arsize_o, bus.arburst_o}, {4'h0, 8'h00, 3'b010, 2'b01});
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_fetch(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            rv.pc       = $urandom & 32'hFFFF_FFFC;
            rv.ar_dly   = $urandom_range(0, 3);
            rv.r_dly    = $urandom_range(0, 3);
            rv.i_dly    = $urandom_range(0, 3);
            rv.rdata    = $urandom;
            rv.rresp    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rv.rid      = ($urandom_range(0, 5) == 0) ? 4'h3 : 4'h0;
            rv.rlast    = ($urandom_range(0, 5) != 0);
            rv.exp_inst = rv.rdata;
            rv.exp_err  = (rv.rresp != 2'b00) || (rv.rid != 4'h0) || !rv.rlast;
            run_fetch(rv);
        end

        // Asynchronous reset while waiting on the R channel.
        bus.pc_valid_i = 1'b1;
        bus.pc_i       = 32'h4000_0000;
        @(negedge clk);
        bus.pc_valid_i = 1'b0;
        bus.arready_i  = 1'b1;
        @(negedge clk);
        bus.arready_i  = 1'b0;
        check("pre_rst_rready", bus.rready_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_arvalid", bus.arvalid_o, 0);
        check("async_rready", bus.rready_o, 0);
        check("async_inst_valid", bus.inst_valid_o, 0);
        check("async_pc_ready", bus.pc_ready_o, 1);
        check("async_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pc_ready", bus.pc_ready_o, 1);
        rv = '{32'h8000_0004, 0, 0, 0, 32'h0010_0093, 2'b00, 4'h0, 1'b1, 32'h0010_0093, 1'b0};
        run_fetch(rv);

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
